// File: rtl/pipeline_stage1_pkg.sv
// Shared definitions for the operand-assembly stage: state encodings,
// the NOP opcode and the operand-count field codes. Also reused by decode.
package pipeline_stage1_pkg;

  // Assembly states; the 2-bit encoding is visible on the debug port.
  typedef enum logic [1:0] {
    S_OPCODE = 2'd0,
    S_IMM_LO = 2'd1,
    S_IMM_HI = 2'd2
  } state_e;

  localparam int OPCODE_NOP = 0;

  // The operand count lives in the top two bits of the opcode byte.
  localparam int CNT_FIELD_BITS = 2;

  localparam logic [1:0] CNT_NONE = 2'b00;  // no operand bytes
  localparam logic [1:0] CNT_ONE  = 2'b01;  // one operand byte
  localparam logic [1:0] CNT_TWO  = 2'b10;  // two operand bytes, low first
  localparam logic [1:0] CNT_RSVD = 2'b11;  // no operand bytes; trappable

endpackage

// File: rtl/pipeline_stage1_count_decode.sv
// operand_count_decode: combinational opcode -> {operand count, illegal}.
// illegal only ever rises when TRAP_EN is set; otherwise the reserved
// count code is an ordinary zero-operand opcode.
module operand_count_decode
  import pipeline_stage1_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit TRAP_EN = 1'b0
) (
  input  logic [WIDTH-1:0] opcode,
  output logic [1:0]       count,
  output logic             illegal
);

  // Low opcode bits do not affect the operand count.
  logic unused_low_bits;

  assign count           = opcode[WIDTH-1 -: CNT_FIELD_BITS];
  assign illegal         = TRAP_EN && (count == CNT_RSVD);
  assign unused_low_bits = ^opcode[WIDTH-CNT_FIELD_BITS-1:0];

endmodule

// File: rtl/pipeline_stage1.sv
// pipeline_stage1: collects an opcode and its 0..2 operand bytes from the
// fetch byte stream and issues opcode + immediate to decode.
// All state updates on the falling clock edge; reset is asynchronous.
// Optional feature: PIPELINE_STAGE1_ILLEGAL_TRAP_EN turns count code 11
// into a one-cycle illegal_trap instead of a zero-operand issue.
//
// Handshake: a byte on instruction_in is consumed at every negedge where
// bus_request is 0; bus_request=1 is a stall and nothing is consumed.
// instr_valid is a one-cycle strobe with no back-pressure: decode must take
// instruction_out/imm_out in the cycle instr_valid is 1. When instr_valid
// is 0, instruction_out is the NOP opcode (a bubble).
module pipeline_stage1
  import pipeline_stage1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bus_request,
  input  logic [WIDTH-1:0]   instruction_in,
  output logic [WIDTH-1:0]   instruction_out,
  output logic [2*WIDTH-1:0] imm_out,
  output logic               instr_valid,
  output logic               operand_fetch,
  output logic               illegal_trap,
  output logic [1:0]         state_dbg
);

`ifdef PIPELINE_STAGE1_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_hold_q, op_hold_d;
  logic [WIDTH-1:0]   imm_lo_q, imm_lo_d;
  logic [WIDTH-1:0]   instr_q, instr_d;
  logic [2*WIDTH-1:0] imm_q, imm_d;
  logic               valid_q, valid_d;
  logic               trap_q, trap_d;

  logic [1:0]         in_count;
  logic               in_illegal;
  logic [1:0]         hold_count;

  operand_count_decode #(
    .WIDTH   (WIDTH),
    .TRAP_EN (TRAP_EN)
  ) u_count_decode (
    .opcode  (instruction_in),
    .count   (in_count),
    .illegal (in_illegal)
  );

  assign hold_count = op_hold_q[WIDTH-1 -: CNT_FIELD_BITS];

  // Next-state and next-output logic for the assembly FSM.
  always_comb begin
    state_d   = state_q;
    op_hold_d = op_hold_q;
    imm_lo_d  = imm_lo_q;
    instr_d   = WIDTH'(OPCODE_NOP);
    imm_d     = imm_q;
    valid_d   = 1'b0;
    trap_d    = trap_q;
    if (!bus_request) begin
      trap_d = 1'b0;
      case (state_q)
        S_OPCODE: begin
          op_hold_d = instruction_in;
          if (in_illegal) begin
            trap_d = 1'b1;
          end else if (in_count == CNT_ONE || in_count == CNT_TWO) begin
            state_d = S_IMM_LO;
          end else begin
            instr_d = instruction_in;
            imm_d   = '0;
            valid_d = 1'b1;
          end
        end
        S_IMM_LO: begin
          if (hold_count == CNT_ONE) begin
            instr_d = op_hold_q;
            imm_d   = {{WIDTH{1'b0}}, instruction_in};
            valid_d = 1'b1;
            state_d = S_OPCODE;
          end else begin
            imm_lo_d = instruction_in;
            state_d  = S_IMM_HI;
          end
        end
        S_IMM_HI: begin
          instr_d = op_hold_q;
          imm_d   = {instruction_in, imm_lo_q};
          valid_d = 1'b1;
          state_d = S_OPCODE;
        end
        default: begin
          state_d = S_OPCODE;
        end
      endcase
    end
  end

  // State and registered outputs, updated on the falling edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_OPCODE;
      op_hold_q <= '0;
      imm_lo_q  <= '0;
      instr_q   <= '0;
      imm_q     <= '0;
      valid_q   <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_hold_q <= op_hold_d;
      imm_lo_q  <= imm_lo_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      valid_q   <= valid_d;
      trap_q    <= trap_d;
    end
  end

  assign instruction_out = instr_q;
  assign imm_out         = imm_q;
  assign instr_valid     = valid_q;
  assign illegal_trap    = trap_q;
  assign operand_fetch   = (state_q == S_IMM_LO) || (state_q == S_IMM_HI);
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_pipeline_stage1.sv
// Directed bench for pipeline_stage1 with hand-computed expectations.
// Inputs change just after a falling edge; outputs are sampled 1 time unit
// after the falling edge that updated them.
module tb_pipeline_stage1;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset;
  logic               bus_request;
  logic [WIDTH-1:0]   instruction_in;
  logic [WIDTH-1:0]   instruction_out;
  logic [2*WIDTH-1:0] imm_out;
  logic               instr_valid;
  logic               operand_fetch;
  logic               illegal_trap;
  logic [1:0]         state_dbg;

  int n_vec;
  int n_miss;

  pipeline_stage1 #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus_request     (bus_request),
    .instruction_in  (instruction_in),
    .instruction_out (instruction_out),
    .imm_out         (imm_out),
    .instr_valid     (instr_valid),
    .operand_fetch   (operand_fetch),
    .illegal_trap    (illegal_trap),
    .state_dbg       (state_dbg)
  );

  // Clock: negedges at 5, 15, 25, ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] instr,
                            input logic [15:0] imm, input logic valid,
                            input logic ofetch, input logic trap,
                            input logic [1:0] st);
    check_val({tag, ".instr"}, 32'(instruction_out), 32'(instr));
    check_val({tag, ".imm"},   32'(imm_out),         32'(imm));
    check_val({tag, ".valid"}, 32'(instr_valid),     32'(valid));
    check_val({tag, ".ofetch"}, 32'(operand_fetch),  32'(ofetch));
    check_val({tag, ".trap"},  32'(illegal_trap),    32'(trap));
    check_val({tag, ".state"}, 32'(state_dbg),       32'(st));
  endtask

  // Present one byte (or a stall) and wait for the edge that acts on it.
  task automatic apply(input logic [7:0] b, input logic br);
    instruction_in = b;
    bus_request    = br;
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_vec          = 0;
    n_miss         = 0;
    reset          = 1'b1;
    bus_request    = 1'b0;
    instruction_in = 8'h00;

    #2;
    expect_out("reset", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back zero-operand opcodes, including the real NOP 0x00.
    apply(8'h05, 1'b0); expect_out("b2b0", 8'h05, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0);
    apply(8'h06, 1'b0); expect_out("b2b1", 8'h06, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0);
    apply(8'h00, 1'b0); expect_out("b2b2", 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0);

    // One-operand opcode.
    apply(8'h47, 1'b0); expect_out("op1a", 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd1);
    apply(8'h9C, 1'b0); expect_out("op1b", 8'h47, 16'h009C, 1'b1, 1'b0, 1'b0, 2'd0);

    // Asynchronous reset in S_IMM_HI discards the partial instruction.
    apply(8'h8A, 1'b0); expect_out("rst_a", 8'h00, 16'h009C, 1'b0, 1'b1, 1'b0, 2'd1);
    apply(8'h34, 1'b0); expect_out("rst_b", 8'h00, 16'h009C, 1'b0, 1'b1, 1'b0, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    expect_out("rst_async", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    apply(8'h05, 1'b0); expect_out("rst_next", 8'h05, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0);

    // Two-operand opcode with a 3-cycle stall in S_IMM_HI.
    apply(8'h8A, 1'b0); expect_out("stl_a", 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd1);
    apply(8'h34, 1'b0); expect_out("stl_b", 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 3; i++) begin
      apply(8'($urandom_range(0, 255)), 1'b1);
      expect_out("stl_hold", 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd2);
    end
    apply(8'h12, 1'b0); expect_out("stl_issue", 8'h8A, 16'h1234, 1'b1, 1'b0, 1'b0, 2'd0);

    // Plain two-operand stream; the next opcode must not re-issue.
    apply(8'h8A, 1'b0); expect_out("op2a", 8'h00, 16'h1234, 1'b0, 1'b1, 1'b0, 2'd1);
    apply(8'h56, 1'b0); expect_out("op2b", 8'h00, 16'h1234, 1'b0, 1'b1, 1'b0, 2'd2);
    apply(8'h78, 1'b0); expect_out("op2c", 8'h8A, 16'h7856, 1'b1, 1'b0, 1'b0, 2'd0);
    apply(8'h40, 1'b0); expect_out("once", 8'h00, 16'h7856, 1'b0, 1'b1, 1'b0, 2'd1);
    apply(8'h7F, 1'b0); expect_out("op1c", 8'h40, 16'h007F, 1'b1, 1'b0, 1'b0, 2'd0);

    // Stall in S_OPCODE: bubble, immediate holds, byte not consumed.
    apply(8'h05, 1'b1); expect_out("stl_op", 8'h00, 16'h007F, 1'b0, 1'b0, 1'b0, 2'd0);
    apply(8'h05, 1'b0); expect_out("stl_op_go", 8'h05, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0);

    // Reserved count code 11.
`ifdef PIPELINE_STAGE1_ILLEGAL_TRAP_EN
    apply(8'hC3, 1'b0); expect_out("trap", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0);
    apply(8'h11, 1'b1); expect_out("trap_stl", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0);
    apply(8'h06, 1'b0); expect_out("trap_clr", 8'h06, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0);
`else
    apply(8'hC3, 1'b0); expect_out("rsvd", 8'hC3, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0);
    apply(8'h11, 1'b1); expect_out("rsvd_stl", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    apply(8'h06, 1'b0); expect_out("rsvd_next", 8'h06, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0);
`endif

    // One-operand followed directly by two-operand opcode.
    apply(8'h41, 1'b0); expect_out("mix_a", 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd1);
    apply(8'hFF, 1'b0); expect_out("mix_b", 8'h41, 16'h00FF, 1'b1, 1'b0, 1'b0, 2'd0);
    apply(8'hBF, 1'b0); expect_out("mix_c", 8'h00, 16'h00FF, 1'b0, 1'b1, 1'b0, 2'd1);
    apply(8'hAA, 1'b0); expect_out("mix_d", 8'h00, 16'h00FF, 1'b0, 1'b1, 1'b0, 2'd2);
    apply(8'hBB, 1'b0); expect_out("mix_e", 8'hBF, 16'hBBAA, 1'b1, 1'b0, 1'b0, 2'd0);

    // Stall and reset together: reset wins, mid S_IMM_LO.
    apply(8'h47, 1'b0); expect_out("rs_a", 8'h00, 16'hBBAA, 1'b0, 1'b1, 1'b0, 2'd1);
    bus_request = 1'b1;
    reset       = 1'b1;
    #1;
    expect_out("rs_both", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    apply(8'h33, 1'b0); expect_out("rs_next", 8'h33, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
